// File: rtl/song_tutor_ctrl_pkg.sv
// Shared definitions for the piano tutor lesson sequencer: note codes, LED decode, FSM states, sizes.
// Pure declarations; no logic and no latency.
package song_tutor_ctrl_pkg;

   localparam int NUM_SONGS       = 4;
   localparam int MAX_STEPS       = 32;
   localparam int IDX_W           = $clog2(MAX_STEPS);
   localparam int SONG_W          = 2;
   localparam int ERR_W           = 8;
   localparam int DEF_HINT_CYCLES = 100_000_000;

   typedef logic [3:0] note_t;

   localparam note_t NOTE_C4   = 4'h0;
   localparam note_t NOTE_D    = 4'h1;
   localparam note_t NOTE_E    = 4'h2;
   localparam note_t NOTE_F    = 4'h3;
   localparam note_t NOTE_G    = 4'h4;
   localparam note_t NOTE_A    = 4'h5;
   localparam note_t NOTE_B    = 4'h6;
   localparam note_t NOTE_C5   = 4'h7;
   localparam note_t NOTE_NONE = 4'hE;
   localparam note_t NOTE_END  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_PRESS,
      ST_WAIT_RELEASE,
      ST_DONE
   } state_t;

   // One LED per key of the C4..C5 octave; anything else is dark.
   function automatic logic [7:0] note_to_led(input note_t n);
      logic [7:0] led;
      led = 8'h00;
      if (n <= NOTE_C5) led = 8'h01 << n;
      return led;
   endfunction

endpackage

// File: rtl/song_tutor_ctrl_if.sv
// Lesson control/status bundle between the key decoder / LED bank side and the tutor sequencer.
// Plain wires; no latency and no flow control.
interface song_tutor_ctrl_if;
   import song_tutor_ctrl_pkg::*;

   logic [SONG_W-1:0] song_sel;
   logic              start;
   logic              abort;
   note_t             note;
   logic [7:0]        Led;
   logic [IDX_W-1:0]  step;
   logic              busy;
   logic              done;
   logic [ERR_W-1:0]  errors;
   logic              hint;

   modport master (
      output song_sel, start, abort, note,
      input  Led, step, busy, done, errors, hint
   );

   modport slave (
      input  song_sel, start, abort, note,
      output Led, step, busy, done, errors, hint
   );

endinterface

// File: rtl/song_tutor_ctrl_rom.sv
// Melody table: {song, idx} -> note code, registered (1-cycle read latency), always ready.
// Unused entries and songs beyond NUM_SONGS read NOTE_END.
module tutor_song_rom
   import song_tutor_ctrl_pkg::*;
(
   input  logic              CLK,
   input  logic [SONG_W-1:0] i_song,
   input  logic [IDX_W-1:0]  i_idx,
   output note_t             o_note
);

   note_t r_note;

   function automatic note_t song_note(input logic [SONG_W-1:0] s, input logic [IDX_W-1:0] i);
      note_t n;
      n = NOTE_END;
      if (int'(s) < NUM_SONGS) begin
         case (s)
            2'd0: begin
               // Ode to Joy
               case (i)
                  5'd0, 5'd1, 5'd6, 5'd11, 5'd12: n = NOTE_E;
                  5'd2, 5'd5:                     n = NOTE_F;
                  5'd3, 5'd4:                     n = NOTE_G;
                  5'd7, 5'd10, 5'd13, 5'd14:      n = NOTE_D;
                  5'd8, 5'd9:                     n = NOTE_C4;
                  default:                        n = NOTE_END;
               endcase
            end
            2'd1: begin
               case (i)
                  5'd0:    n = NOTE_C4;
                  5'd1:    n = NOTE_D;
                  5'd2:    n = NOTE_E;
                  5'd3:    n = NOTE_F;
                  5'd4:    n = NOTE_G;
                  default: n = NOTE_END;
               endcase
            end
            2'd2: begin
               case (i)
                  5'd0, 5'd1, 5'd4: n = NOTE_G;
                  5'd2, 5'd3:       n = NOTE_A;
                  default:          n = NOTE_END;
               endcase
            end
            default: n = NOTE_END;
         endcase
      end
      return n;
   endfunction

   always_ff @(posedge CLK) begin
      r_note <= song_note(i_song, i_idx);
   end

   assign o_note = r_note;

endmodule

// File: rtl/song_tutor_ctrl.sv
// Piano lesson sequencer: all outputs registered, one FETCH cycle per note, no backpressure.
// TUTOR_STRICT_EN: a wrong press restarts the song from step 0 (errors keep counting).
module song_tutor_ctrl
   import song_tutor_ctrl_pkg::*;
#(
   parameter int HINT_CYCLES = DEF_HINT_CYCLES
) (
   input  logic             CLK,
   input  logic             RESET,
   song_tutor_ctrl_if.slave bus
);

   localparam int HINT_W = $clog2(HINT_CYCLES + 1);

   state_t            r_state, w_state_nxt;
   logic [SONG_W-1:0] r_song, w_song_nxt;
   logic [IDX_W-1:0]  r_step, w_step_nxt;
   note_t             r_target, w_target_nxt;
   note_t             r_prev_note;
   note_t             w_rom_note;
   logic [7:0]        r_led, w_led_nxt;
   logic [ERR_W-1:0]  r_errors, w_errors_nxt;
   logic [HINT_W-1:0] r_hint_cnt, w_hint_cnt_nxt;
   logic              r_hint, w_hint_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              w_wrong_press;
   logic              w_stay_wait;

   // Address from next-state values so the registered ROM data is valid during FETCH.
   tutor_song_rom u_rom (
      .CLK    (CLK),
      .i_song (w_song_nxt),
      .i_idx  (w_step_nxt),
      .o_note (w_rom_note)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_song_nxt     = r_song;
      w_step_nxt     = r_step;
      w_target_nxt   = r_target;
      w_led_nxt      = r_led;
      w_errors_nxt   = r_errors;
      w_hint_cnt_nxt = '0;
      w_hint_nxt     = 1'b0;
      w_stay_wait    = 1'b0;

      // Only a NONE -> wrong-key edge counts, so holding a wrong key is one error.
      w_wrong_press = (r_state == ST_WAIT_PRESS) && (r_prev_note == NOTE_NONE) &&
                      (bus.note != NOTE_NONE) && (bus.note != r_target);

      if (bus.abort) begin
         w_state_nxt = ST_IDLE;
         w_step_nxt  = '0;
         w_led_nxt   = 8'h00;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  w_song_nxt   = bus.song_sel;
                  w_step_nxt   = '0;
                  w_errors_nxt = '0;
                  w_led_nxt    = 8'h00;
                  w_state_nxt  = ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (w_rom_note == NOTE_END) begin
                  w_state_nxt = ST_DONE;
                  w_led_nxt   = 8'hFF;
               end else begin
                  w_target_nxt = w_rom_note;
                  w_led_nxt    = note_to_led(w_rom_note);
                  w_state_nxt  = ST_WAIT_PRESS;
               end
            end
            ST_WAIT_PRESS: begin
               if (bus.note == r_target) begin
                  w_state_nxt = ST_WAIT_RELEASE;
               end else if (w_wrong_press) begin
                  if (r_errors != '1) w_errors_nxt = r_errors + 1'b1;
`ifdef TUTOR_STRICT_EN
                  w_step_nxt  = '0;
                  w_state_nxt = ST_FETCH;
`endif
               end
            end
            ST_WAIT_RELEASE: begin
               if (bus.note == NOTE_NONE) begin
                  if (r_step == IDX_W'(MAX_STEPS - 1)) begin
                     w_state_nxt = ST_DONE;
                     w_led_nxt   = 8'hFF;
                  end else begin
                     w_step_nxt  = r_step + 1'b1;
                     w_state_nxt = ST_FETCH;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_step_nxt  = '0;
               w_led_nxt   = 8'h00;
            end
         endcase
      end

      // Hint timer restarts whenever WAIT_PRESS is entered or left.
      w_stay_wait = (r_state == ST_WAIT_PRESS) && (w_state_nxt == ST_WAIT_PRESS);
      if (w_stay_wait) begin
         w_hint_cnt_nxt = (r_hint_cnt != HINT_W'(HINT_CYCLES)) ? r_hint_cnt + 1'b1 : r_hint_cnt;
         w_hint_nxt     = r_hint || (r_hint_cnt == HINT_W'(HINT_CYCLES - 1));
      end

      w_busy_nxt = (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_WAIT_PRESS) ||
                   (w_state_nxt == ST_WAIT_RELEASE);
      w_done_nxt = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_song      <= '0;
         r_step      <= '0;
         r_target    <= NOTE_NONE;
         r_prev_note <= NOTE_NONE;
         r_led       <= 8'h00;
         r_errors    <= '0;
         r_hint_cnt  <= '0;
         r_hint      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_song      <= w_song_nxt;
         r_step      <= w_step_nxt;
         r_target    <= w_target_nxt;
         r_prev_note <= bus.note;
         r_led       <= w_led_nxt;
         r_errors    <= w_errors_nxt;
         r_hint_cnt  <= w_hint_cnt_nxt;
         r_hint      <= w_hint_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   assign bus.Led    = r_led;
   assign bus.step   = r_step;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.errors = r_errors;
   assign bus.hint   = r_hint;

endmodule

// File: tb/tb_song_tutor_ctrl.sv
// Directed bench for song_tutor_ctrl (HINT_CYCLES=10); honours TUTOR_STRICT_EN when defined.
module tb_song_tutor_ctrl;
   import song_tutor_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   song_tutor_ctrl_if bus();

   song_tutor_ctrl #(.HINT_CYCLES(10)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Ode to Joy: E E F G G F E D C C D E E D D
   note_t      ode_note [15] = '{4'h2, 4'h2, 4'h3, 4'h4, 4'h4, 4'h3, 4'h2, 4'h1,
                                 4'h0, 4'h0, 4'h1, 4'h2, 4'h2, 4'h1, 4'h1};
   logic [7:0] ode_led  [15] = '{8'h04, 8'h04, 8'h08, 8'h10, 8'h10, 8'h08, 8'h04, 8'h02,
                                 8'h01, 8'h01, 8'h02, 8'h04, 8'h04, 8'h02, 8'h02};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start pulse, then FETCH; returns with the DUT in WAIT_PRESS (or DONE for an empty song).
   task automatic begin_song(input logic [1:0] s);
      bus.song_sel = s;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      tick();
   endtask

   task automatic press_release(input note_t n);
      bus.note = n;
      tick();
      bus.note = NOTE_NONE;
      tick();
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.note     = NOTE_NONE;
      bus.song_sel = 2'd0;
      tick();
      tick();
      check("rst_led",    bus.Led,    8'h00);
      check("rst_step",   bus.step,   0);
      check("rst_busy",   bus.busy,   0);
      check("rst_done",   bus.done,   0);
      check("rst_errors", bus.errors, 0);
      check("rst_hint",   bus.hint,   0);
      rst = 1'b0;
      tick();

      // start and abort together: abort wins
      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("sa_busy", bus.busy, 0);
      check("sa_led",  bus.Led,  8'h00);
      tick();
      check("sa_busy2", bus.busy, 0);

      // full pass through song 0
      begin_song(2'd0);
      for (int i = 0; i < 15; i++) begin
         check("s0_step", bus.step, i);
         check("s0_led",  bus.Led,  ode_led[i]);
         check("s0_busy", bus.busy, 1);
         if (i == 3) begin
            bus.song_sel = 2'd1;
            bus.start    = 1'b1;
            tick();
            bus.start    = 1'b0;
            check("busy_start_step", bus.step, 3);
            check("busy_start_led",  bus.Led,  8'h10);
         end
`ifndef TUTOR_STRICT_EN
         if (i == 2) begin
            bus.note = NOTE_G;
            tick();
            check("wrong_err1", bus.errors, 1);
            repeat (4) tick();
            check("wrong_hold_err", bus.errors, 1);
            check("wrong_hold_step", bus.step, 2);
            bus.note = NOTE_NONE;
            tick();
            check("wrong_rel_err",  bus.errors, 1);
            check("wrong_rel_step", bus.step, 2);
            check("wrong_rel_led",  bus.Led, 8'h08);
         end
`endif
         bus.note = ode_note[i];
         tick();
         check("s0_wr_led", bus.Led, ode_led[i]);
         bus.note = NOTE_NONE;
         tick();
         tick();
      end
      check("s0_done",  bus.done, 1);
      check("s0_ffled", bus.Led,  8'hFF);
      check("s0_idle",  bus.busy, 0);
`ifdef TUTOR_STRICT_EN
      check("s0_errors", bus.errors, 0);
`else
      check("s0_errors", bus.errors, 1);
`endif
      tick();
      check("s0_done_pulse", bus.done, 0);
      check("s0_ffled2",     bus.Led,  8'hFF);

`ifdef TUTOR_STRICT_EN
      begin_song(2'd0);
      for (int i = 0; i < 5; i++) press_release(ode_note[i]);
      check("strict_step5", bus.step, 5);
      bus.note = NOTE_G;
      tick();
      bus.note = NOTE_NONE;
      tick();
      check("strict_step0", bus.step,   0);
      check("strict_led",   bus.Led,    8'h04);
      check("strict_err",   bus.errors, 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
`endif

      // idle hint on song 1 (C D E F G)
      begin_song(2'd1);
      check("start_clr_err", bus.errors, 0);
      repeat (9) tick();
      check("hint_early", bus.hint, 0);
      tick();
      check("hint_set", bus.hint, 1);
      repeat (3) tick();
      check("hint_hold", bus.hint, 1);
      bus.note = NOTE_C4;
      tick();
      check("hint_clr",   bus.hint, 0);
      check("s1_led0",    bus.Led,  8'h01);
      bus.note = NOTE_NONE;
      tick();
      tick();
      check("s1_step1",   bus.step, 1);
      check("s1_led1",    bus.Led,  8'h02);
      bus.note = NOTE_G;
      tick();
      bus.note = NOTE_NONE;
      tick();
      tick();
      check("s1_err", bus.errors, 1);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_busy", bus.busy,   0);
      check("abort_led",  bus.Led,    8'h00);
      check("abort_step", bus.step,   0);
      check("abort_hint", bus.hint,   0);
      check("abort_err",  bus.errors, 1);
      check("abort_done", bus.done,   0);

      // song 3 is empty: completes straight from FETCH
      begin_song(2'd3);
      check("s3_done", bus.done,   1);
      check("s3_led",  bus.Led,    8'hFF);
      check("s3_busy", bus.busy,   0);
      check("s3_err",  bus.errors, 0);
      tick();
      check("s3_done_pulse", bus.done, 0);

      // reset in the middle of a lesson
      begin_song(2'd0);
      bus.note = NOTE_G;
      tick();
      bus.note = NOTE_NONE;
      tick();
      check("mid_err", bus.errors, 1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_led",  bus.Led,    8'h00);
      check("arst_busy", bus.busy,   0);
      check("arst_err",  bus.errors, 0);
      tick();
      check("arst_step", bus.step, 0);
      check("arst_hint", bus.hint, 0);
      check("arst_done", bus.done, 0);
      rst = 1'b0;
      tick();

      // error counter saturation
      begin_song(2'd0);
      for (int k = 0; k < 255; k++) begin
         bus.note = NOTE_G;
         tick();
         bus.note = NOTE_NONE;
         tick();
      end
      check("err_255", bus.errors, 8'hFF);
      bus.note = NOTE_G;
      tick();
      bus.note = NOTE_NONE;
      tick();
      check("err_sat", bus.errors, 8'hFF);
      check("err_sat_busy", bus.busy, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
